bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Sequences all writes into the branch predictor's pattern tables.
- The per-PC history table (PHT) holds 256 entries of 2-bit local history. The counter table (BHT) holds 1024 entries of 2-bit saturating counters.
- After reset, sweeps both tables to their initial values, one index per cycle.
- Then accepts up to two committed-branch outcomes per cycle from the ROB, buffers them in a FIFO, and retires one per cycle through a 2-stage read-modify-write pipeline with history forwarding.

Parameters:
- ADDR_CUT_LEN, 8, PC bits [9:2] used as PHT index.
- PATTERN_LEN, 2, local history length; BHT index = {pc_cut, pattern}.
- QUEUE_DEPTH, 8, update FIFO entries (power of two, >=4).
- BHT_INIT, 2'b10, counter reset value (weakly taken).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- upd0_valid_in  in  1  commit slot 0 carries a resolved branch.
- upd0_pc_in  in  32  its PC.
- upd0_taken_in  in  1  its outcome.
- upd1_valid_in, upd1_pc_in, upd1_taken_in  in  1/32/1  commit slot 1, younger than slot 0.
- upd_ready_out  out  1  both slots may push this cycle.
- init_busy_out  out  1  table sweep in progress.
- pht_raddr_out  out  8  PHT read index (combinational read).
- pht_rdata_in  in  2  PHT read data.
- pht_we_out, pht_waddr_out, pht_wdata_out  out  1/8/2  PHT write port (written at clk edge).
- bht_raddr_out  out  10  BHT read index (combinational read).
- bht_rdata_in  in  2  BHT read data.
- bht_we_out, bht_waddr_out, bht_wdata_out  out  1/10/2  BHT write port.

Behaviour:
- Reset (rst_n low, async):
  - FIFO emptied; E1/E2 valid cleared; sweep index = 0.
  - State = INIT; init_busy_out = 1; upd_ready_out = 0; all we = 0.
  - Reset asserted mid-operation discards queued and in-flight updates, and the sweep restarts from 0.
- FSM INIT (one index per cycle):
  - bht_we = 1, bht_waddr = idx, bht_wdata = BHT_INIT.
  - pht_we = (idx < 256), pht_waddr = idx[7:0], pht_wdata = 0.
  - idx increments each cycle; after idx = 1023 is written, next state = RUN. The sweep takes exactly 1024 cycles.
- FSM RUN: init_busy_out = 0; no exit except reset.
- Push (RUN only):
  - upd_ready_out = (count <= QUEUE_DEPTH-2), independent of a same-cycle pop.
  - Push happens when upd_ready_out && valid. Slot 0 is written before slot 1.
  - Slot 1 valid alone pushes one entry. Valids with ready low are dropped; the ROB must hold them.
- Pop:
  - If FIFO is non-empty, the head moves into E1 at the clock edge (one per cycle).
  - The count update handles push of 0, 1 or 2 together with a simultaneous pop.
  - Pointers wrap modulo QUEUE_DEPTH.
- E1 stage:
  - pht_raddr = E1.cut.
  - pattern = (E2.valid && E2.cut == E1.cut) ? {E2.pattern[0], E2.taken} : pht_rdata_in.
  - At the edge, E2 <= {cut, pattern, taken}.
- E2 stage:
  - bht_raddr = bht_waddr = {E2.cut, E2.pattern}; bht_we = 1.
  - bht_wdata = taken ? (rdata == 2'b11 ? 2'b11 : rdata+1) : (rdata == 2'b00 ? 2'b00 : rdata-1).
  - pht_we = 1, pht_waddr = E2.cut, pht_wdata = {E2.pattern[0], E2.taken}.
- Latency: an entry pushed at edge T (FIFO empty, pipe idle) is in E1 during cycle T+2 and E2 during T+3, and is written at the edge ending T+3.
- BHT RAW between consecutive E2 entries needs no forwarding: the write lands before the next E2 read.

Decomposition:
- bp_pkg:
  - widths ADDR_CUT_LEN, PATTERN_LEN, BHT_IDX_W = 10.
  - constants for the 2-bit counter encodings (00/01/10/11) and BHT_INIT.
  - sat_update(cnt, taken) function.
  - update-entry struct {cut[7:0], taken}.
- Sub-module bp_upd_fifo: 2-push / 1-pop FIFO with count output, async active-low clear.

Test Plan:
- Reset release:
  - init_busy_out = 1 for 1024 cycles.
  - BHT writes idx 0..1023 with 2'b10; PHT writes 0..255 with 2'b00, none after that.
  - Cycle 1025: init_busy_out = 0, upd_ready_out = 1.
- Single update, pc=0x104 taken, pht model 00, bht model 10:
  - 3 cycles later: bht_waddr=0x104, wdata=2'b11; pht_waddr=0x41, wdata=2'b01.
- Dual push in one cycle, pc 0x104 taken (slot 0) then pc 0x104 not-taken (slot 1):
  - Second entry forwards pattern 01 → bht_waddr=0x105; pht_wdata=2'b10.
- Saturation:
  - rdata=11 with taken → wdata 11.
  - rdata=00 with not-taken → wdata 00.
- Queue full, dual pushes every cycle with QUEUE_DEPTH=8:
  - upd_ready_out drops when count reaches 7.
  - Entries retire strictly in push order, one per cycle; no loss or duplication across pointer wrap.
- Async reset mid-run with 5 queued entries:
  - Within the same cycle: all we=0, upd_ready_out=0, init_busy_out=1.
  - After release the sweep restarts at idx 0, and no stale update is ever written.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared widths, counter encodings and bundle types for the
// branch-predictor update scheduler.
package bp_pkg;

    localparam int ADDR_CUT_LEN = 8;
    localparam int PATTERN_LEN  = 2;
    localparam int BHT_IDX_W    = ADDR_CUT_LEN + PATTERN_LEN;
    localparam int QUEUE_DEPTH  = 8;
    localparam int PHT_ENTRIES  = 1 << ADDR_CUT_LEN;

    localparam logic [1:0] CNT_SN   = 2'b00;
    localparam logic [1:0] CNT_WN   = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;
    localparam logic [1:0] BHT_INIT = CNT_WT;

    typedef logic [ADDR_CUT_LEN-1:0] cut_t;
    typedef logic [PATTERN_LEN-1:0]  pat_t;

    typedef struct packed {
        cut_t cut;
        logic taken;
    } upd_t;

    typedef struct packed {
        logic valid;
        cut_t cut;
        pat_t pattern;
        logic taken;
    } e2_t;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    function automatic logic [1:0] sat_update(
        input logic [1:0] cnt,
        input logic       taken
    );
        logic [1:0] r;
        if (taken) r = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        else       r = (cnt == CNT_SN) ? CNT_SN : cnt - 2'd1;
        return r;
    endfunction

    function automatic cut_t pc_cut(input logic [31:0] pc);
        return pc[ADDR_CUT_LEN+1:2];
    endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// Two-slot commit handshake between the ROB and the
// predictor update scheduler.
interface bp_update_sched_if;

    logic        upd0_valid_in;
    logic [31:0] upd0_pc_in;
    logic        upd0_taken_in;
    logic        upd1_valid_in;
    logic [31:0] upd1_pc_in;
    logic        upd1_taken_in;
    logic        upd_ready_out;

    modport master (
        output upd0_valid_in,
        output upd0_pc_in,
        output upd0_taken_in,
        output upd1_valid_in,
        output upd1_pc_in,
        output upd1_taken_in,
        input  upd_ready_out
    );

    modport slave (
        input  upd0_valid_in,
        input  upd0_pc_in,
        input  upd0_taken_in,
        input  upd1_valid_in,
        input  upd1_pc_in,
        input  upd1_taken_in,
        output upd_ready_out
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// Two-push / one-pop update FIFO; slot 0 lands ahead of slot 1.
// Power-of-two depth so pointers wrap naturally.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = QUEUE_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0_i,
    input  upd_t          data0_i,
    input  logic          push1_i,
    input  upd_t          data1_i,
    input  logic          pop_i,
    output upd_t          head_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] widx1;
    logic [CW-1:0] cnt_q, cnt_d;
    upd_t          mem_q [DEPTH];

    always_comb begin
        widx1  = wptr_q + PW'(push0_i);
        wptr_d = widx1 + PW'(push1_i);
        rptr_d = rptr_q + PW'(pop_i);
        cnt_d  = cnt_q + CW'(push0_i) + CW'(push1_i)
               - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wptr_q] <= data0_i;
        if (push1_i) mem_q[widx1]  <= data1_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/bp_update_sched.sv
// Sweeps the PHT/BHT after reset, then retires committed branch
// outcomes through a 2-stage read-modify-write pipeline.
module bp_update_sched
    import bp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    bp_update_sched_if.slave        upd_if,
    output logic                    init_busy_out,
    output logic [ADDR_CUT_LEN-1:0] pht_raddr_out,
    input  logic [1:0]              pht_rdata_in,
    output logic                    pht_we_out,
    output logic [ADDR_CUT_LEN-1:0] pht_waddr_out,
    output logic [1:0]              pht_wdata_out,
    output logic [BHT_IDX_W-1:0]    bht_raddr_out,
    input  logic [1:0]              bht_rdata_in,
    output logic                    bht_we_out,
    output logic [BHT_IDX_W-1:0]    bht_waddr_out,
    output logic [1:0]              bht_wdata_out
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    state_e                state_q;
    logic [BHT_IDX_W-1:0]  idx_q;
    logic [CW-1:0]         fifo_cnt;
    upd_t                  fifo_head;
    upd_t                  e1_q;
    logic                  e1_valid_q;
    e2_t                   e2_q, e2_d;
    logic                  ready, push0, push1, pop;
    logic [BHT_IDX_W-1:0]  e2_idx;

    assign ready = (state_q == S_RUN)
                && (fifo_cnt <= CW'(QUEUE_DEPTH - 2));
    assign push0 = ready && upd_if.upd0_valid_in;
    assign push1 = ready && upd_if.upd1_valid_in;
    assign pop   = (fifo_cnt != '0);

    bp_upd_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push0_i (push0),
        .data0_i ('{cut: pc_cut(upd_if.upd0_pc_in),
                    taken: upd_if.upd0_taken_in}),
        .push1_i (push1),
        .data1_i ('{cut: pc_cut(upd_if.upd1_pc_in),
                    taken: upd_if.upd1_taken_in}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    // E2 writes this cut's history at the edge, so E1 must see it now.
    always_comb begin
        e2_d         = '0;
        e2_d.valid   = e1_valid_q;
        e2_d.cut     = e1_q.cut;
        e2_d.taken   = e1_q.taken;
        e2_d.pattern = pht_rdata_in;
        if (e2_q.valid && (e2_q.cut == e1_q.cut))
            e2_d.pattern = {e2_q.pattern[PATTERN_LEN-2:0],
                            e2_q.taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            idx_q      <= '0;
            e1_valid_q <= 1'b0;
            e1_q       <= '0;
            e2_q       <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == '1) state_q <= S_RUN;
                end
                S_RUN: ;
            endcase
            e1_valid_q <= pop;
            if (pop) e1_q <= fifo_head;
            e2_q <= e2_d;
        end
    end

    assign e2_idx = {e2_q.cut, e2_q.pattern};

    // Write enables are gated by rst_n so nothing lands while held.
    always_comb begin
        init_busy_out        = (state_q == S_INIT);
        upd_if.upd_ready_out = ready;
        pht_raddr_out        = e1_q.cut;
        bht_raddr_out        = e2_idx;
        bht_we_out           = rst_n && e2_q.valid;
        bht_waddr_out        = e2_idx;
        bht_wdata_out        = sat_update(bht_rdata_in,
                                          e2_q.taken);
        pht_we_out           = rst_n && e2_q.valid;
        pht_waddr_out        = e2_q.cut;
        pht_wdata_out        = {e2_q.pattern[PATTERN_LEN-2:0],
                                e2_q.taken};
        if (state_q == S_INIT) begin
            bht_we_out    = rst_n;
            bht_waddr_out = idx_q;
            bht_wdata_out = BHT_INIT;
            pht_we_out    = rst_n
                         && (idx_q < BHT_IDX_W'(PHT_ENTRIES));
            pht_waddr_out = idx_q[ADDR_CUT_LEN-1:0];
            pht_wdata_out = '0;
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: table memories, reference predictor
// model and a write scoreboard.
module tb_bp_update_sched;
    import bp_pkg::*;

    typedef struct packed {
        logic [9:0] ba;
        logic [1:0] bd;
        logic [7:0] pa;
        logic [1:0] pd;
    } wr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        wr_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bp_update_sched_if uif ();

    logic       init_busy;
    logic [7:0] pht_raddr, pht_waddr;
    logic [1:0] pht_rdata, pht_wdata, bht_rdata, bht_wdata;
    logic       pht_we, bht_we;
    logic [9:0] bht_raddr, bht_waddr;

    logic [1:0] pht_mem [256];
    logic [1:0] bht_mem [1024];

    assign pht_rdata = pht_mem[pht_raddr];
    assign bht_rdata = bht_mem[bht_raddr];

    always @(posedge clk) begin
        if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
        if (bht_we) bht_mem[bht_waddr] <= bht_wdata;
    end

    bp_update_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .upd_if        (uif),
        .init_busy_out (init_busy),
        .pht_raddr_out (pht_raddr),
        .pht_rdata_in  (pht_rdata),
        .pht_we_out    (pht_we),
        .pht_waddr_out (pht_waddr),
        .pht_wdata_out (pht_wdata),
        .bht_raddr_out (bht_raddr),
        .bht_rdata_in  (bht_rdata),
        .bht_we_out    (bht_we),
        .bht_waddr_out (bht_waddr),
        .bht_wdata_out (bht_wdata)
    );

    int         nvec = 0;
    int         nerr = 0;
    wr_t        sb [$];
    int         cnt_exp;
    logic [1:0] ref_pht [256];
    logic [1:0] ref_bht [1024];
    logic       ovr_en;
    wr_t        ovr_exp;
    logic       saw_full;
    vec_t       vecs [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_pht[i] = 2'b00;
        for (int i = 0; i < 1024; i++) ref_bht[i] = 2'b10;
    endtask

    task automatic model(input logic [31:0] pc, input logic tk,
                         output wr_t e);
        logic [7:0] c;
        logic [1:0] p, old, nw;
        c   = pc[9:2];
        p   = ref_pht[c];
        old = ref_bht[{c, p}];
        if (tk) nw = (old == 2'b11) ? 2'b11 : old + 2'd1;
        else    nw = (old == 2'b00) ? 2'b00 : old - 2'd1;
        e.ba = {c, p};
        e.bd = nw;
        e.pa = c;
        e.pd = {p[0], tk};
        ref_bht[{c, p}] = nw;
        ref_pht[c] = {p[0], tk};
    endtask

    task automatic monitor();
        wr_t e;
        if (sb.size() == 0) begin
            chk("idle_bht_we", bht_we, 0);
            chk("idle_pht_we", pht_we, 0);
        end else if (bht_we) begin
            e = sb.pop_front();
            chk("bht_waddr", bht_waddr, e.ba);
            chk("bht_wdata", bht_wdata, e.bd);
            chk("pht_we", pht_we, 1);
            chk("pht_waddr", pht_waddr, e.pa);
            chk("pht_wdata", pht_wdata, e.pd);
        end
    endtask

    // Called just after a rising edge; returns just after the next.
    task automatic step(input logic v0, input logic [31:0] pc0,
                        input logic t0, input logic v1,
                        input logic [31:0] pc1, input logic t1);
        wr_t e;
        int  n;
        uif.upd0_valid_in = v0;
        uif.upd0_pc_in    = pc0;
        uif.upd0_taken_in = t0;
        uif.upd1_valid_in = v1;
        uif.upd1_pc_in    = pc1;
        uif.upd1_taken_in = t1;
        @(negedge clk);
        monitor();
        chk("ready", uif.upd_ready_out, cnt_exp <= 6);
        if (!uif.upd_ready_out) saw_full = 1'b1;
        n = 0;
        if (uif.upd_ready_out) begin
            if (v0) begin
                model(pc0, t0, e);
                if (ovr_en) e = ovr_exp;
                sb.push_back(e);
                n++;
            end
            if (v1) begin
                model(pc1, t1, e);
                sb.push_back(e);
                n++;
            end
        end
        cnt_exp = cnt_exp + n - ((cnt_exp > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        uif.upd0_valid_in = 1'b0;
        uif.upd1_valid_in = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 24 && sb.size() != 0; k++) idle();
        chk("drain_left", sb.size(), 0);
    endtask

    // Entered just after the rising edge that follows reset release.
    task automatic sweep_check();
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            chk("sweep_busy", init_busy, 1);
            chk("sweep_ready", uif.upd_ready_out, 0);
            chk("sweep_bht_we", bht_we, 1);
            chk("sweep_bht_waddr", bht_waddr, i);
            chk("sweep_bht_wdata", bht_wdata, 2'b10);
            chk("sweep_pht_we", pht_we, (i < 256) ? 1 : 0);
            if (i < 256) begin
                chk("sweep_pht_waddr", pht_waddr, i);
                chk("sweep_pht_wdata", pht_wdata, 0);
            end
        end
        @(negedge clk);
        chk("run_busy", init_busy, 0);
        chk("run_ready", uif.upd_ready_out, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rpc();
        logic [7:0] c;
        c = 8'h50 + 8'($urandom_range(0, 3));
        return {22'($urandom), c, 2'b00};
    endfunction

    initial begin
        vecs[0] = '{32'h0000_0104, 1'b1, '{10'h104, 2'b11, 8'h41, 2'b01}};
        vecs[1] = '{32'h0000_0104, 1'b1, '{10'h105, 2'b11, 8'h41, 2'b11}};
        vecs[2] = '{32'h0000_0104, 1'b1, '{10'h107, 2'b11, 8'h41, 2'b11}};
        vecs[3] = '{32'h0000_0104, 1'b1, '{10'h107, 2'b11, 8'h41, 2'b11}};
        vecs[4] = '{32'h0000_0200, 1'b0, '{10'h200, 2'b01, 8'h80, 2'b00}};
        vecs[5] = '{32'h0000_0200, 1'b0, '{10'h200, 2'b00, 8'h80, 2'b00}};
        vecs[6] = '{32'h0000_0200, 1'b0, '{10'h200, 2'b00, 8'h80, 2'b00}};
        vecs[7] = '{32'h0000_03FC, 1'b1, '{10'h3FC, 2'b11, 8'hFF, 2'b01}};
        vecs[8] = '{32'hFFFF_F000, 1'b0, '{10'h000, 2'b01, 8'h00, 2'b00}};
        vecs[9] = '{32'h1234_5104, 1'b1, '{10'h107, 2'b11, 8'h41, 2'b11}};

        uif.upd0_valid_in = 1'b0;
        uif.upd0_pc_in    = '0;
        uif.upd0_taken_in = 1'b0;
        uif.upd1_valid_in = 1'b0;
        uif.upd1_pc_in    = '0;
        uif.upd1_taken_in = 1'b0;
        ref_init();
        cnt_exp  = 0;
        ovr_en   = 1'b0;
        ovr_exp  = '0;
        saw_full = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", init_busy, 1);
        chk("rst_ready", uif.upd_ready_out, 0);
        chk("rst_bht_we", bht_we, 0);
        chk("rst_pht_we", pht_we, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sweep_check();

        for (int i = 0; i < 10; i++) begin
            ovr_en  = 1'b1;
            ovr_exp = vecs[i].exp;
            step(1'b1, vecs[i].pc, vecs[i].tk, 1'b0, 32'h0, 1'b0);
            ovr_en  = 1'b0;
            drain();
        end

        step(1'b1, 32'h108, 1'b1, 1'b1, 32'h108, 1'b0);
        drain();
        chk("dual_bht108", bht_mem[10'h108], 2'b11);
        chk("dual_bht109", bht_mem[10'h109], 2'b01);
        chk("dual_pht42", pht_mem[8'h42], 2'b10);

        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h3F0, 1'b1);
        drain();
        chk("slot1_pht", pht_mem[8'hFC], 2'b01);

        saw_full = 1'b0;
        repeat (14) step(1'b1, rpc(), 1'($urandom),
                         1'b1, rpc(), 1'($urandom));
        chk("saw_full", saw_full, 1);
        repeat (24) step(1'($urandom), rpc(), 1'($urandom),
                         1'($urandom), rpc(), 1'($urandom));
        drain();

        repeat (4) step(1'b1, rpc(), 1'b1, 1'b1, rpc(), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bht_we", bht_we, 0);
        chk("mid_rst_pht_we", pht_we, 0);
        chk("mid_rst_ready", uif.upd_ready_out, 0);
        chk("mid_rst_busy", init_busy, 1);
        sb.delete();
        cnt_exp = 0;
        ref_init();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sweep_check();
        repeat (8) idle();

        ovr_en  = 1'b1;
        ovr_exp = vecs[0].exp;
        step(1'b1, 32'h104, 1'b1, 1'b0, 32'h0, 1'b0);
        ovr_en  = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
